// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the post-commit store write buffer.
// Contents:
//   WB_DEPTH, WB_BITS : buffer depth and its pointer width
//   SQ_BITS           : store-queue index width of the upstream queue
//   wb_entry_t        : one buffered quadword store {valid, addr[63:3], data}
//   wb_ptr_inc        : circular pointer increment (wraps modulo WB_DEPTH)
package store_write_buffer_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_BITS  = 2;
    localparam int SQ_BITS  = 3;

    typedef struct packed {
        logic        valid;
        logic [60:0] addr;   // quadword address, byte address bits [63:3]
        logic [63:0] data;
    } wb_entry_t;

    function automatic logic [WB_BITS-1:0] wb_ptr_inc(input logic [WB_BITS-1:0] ptr);
        return ptr + WB_BITS'(1);
    endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// Age-ordered store-to-load forwarding comparator.
// Entries are rotated so that position 0 is the head (oldest); a later match
// overrides an earlier one, and the incoming store overrides every buffer entry.
// Ports:
//   entries      : in  buffer contents
//   head         : in  index of the oldest entry
//   lookup_valid : in  probe valid; when low, hit/data are forced to 0
//   lookup_qaddr : in  probe quadword address
//   in_valid     : in  incoming store is being accepted this cycle
//   in_qaddr     : in  incoming store quadword address
//   in_data      : in  incoming store data
//   hit          : out youngest match found
//   data         : out data of youngest match, 0 when no hit
module wb_fwd_match
    import store_write_buffer_pkg::*;
(
    input  wb_entry_t [WB_DEPTH-1:0] entries,
    input  logic [WB_BITS-1:0]       head,
    input  logic                     lookup_valid,
    input  logic [60:0]              lookup_qaddr,
    input  logic                     in_valid,
    input  logic [60:0]              in_qaddr,
    input  logic [63:0]              in_data,
    output logic                     hit,
    output logic [63:0]              data
);

    wb_entry_t [WB_DEPTH-1:0] aged_s;

    // Rotate entries into oldest-first order
    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            aged_s[i] = entries[head + WB_BITS'(i)];
        end
    end

    // Youngest-wins priority match across buffer and incoming store
    always_comb begin
        hit  = 1'b0;
        data = 64'd0;
        if (lookup_valid) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                if (aged_s[i].valid && (aged_s[i].addr == lookup_qaddr)) begin
                    hit  = 1'b1;
                    data = aged_s[i].data;
                end else begin
                    hit  = hit;
                    data = data;
                end
            end
            if (in_valid && (in_qaddr == lookup_qaddr)) begin
                hit  = 1'b1;
                data = in_data;
            end else begin
                hit  = hit;
                data = data;
            end
        end else begin
            hit  = 1'b0;
            data = 64'd0;
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer between the store queue and the D-cache.
// Accepts one committed quadword store per cycle, coalesces into the youngest
// non-head entry, drains in order to the D-cache write port and forwards
// buffered or incoming store data to load probes.
// Ports:
//   clock, reset                 : clock, async active-high reset
//   sq_store_request/addr/data   : in  committed store from the store queue
//   sq_store_success             : out store accepted this cycle (combinational)
//   dc_wr_request/addr/data      : out head entry write to the D-cache
//   dc_wr_ack                    : in  D-cache accepted the write
//   ld_lookup_valid/addr         : in  load forwarding probe
//   ld_fwd_hit/data              : out forwarding result (combinational)
//   wb_count, wb_empty, wb_full  : out occupancy status
module store_write_buffer
    import store_write_buffer_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               sq_store_request,
    input  logic [63:0]        sq_store_addr,
    input  logic [63:0]        sq_store_data,
    output logic               sq_store_success,
    output logic               dc_wr_request,
    output logic [63:0]        dc_wr_addr,
    output logic [63:0]        dc_wr_data,
    input  logic               dc_wr_ack,
    input  logic               ld_lookup_valid,
    input  logic [63:0]        ld_lookup_addr,
    output logic               ld_fwd_hit,
    output logic [63:0]        ld_fwd_data,
    output logic [WB_BITS:0]   wb_count,
    output logic               wb_empty,
    output logic               wb_full
);

    wb_entry_t [WB_DEPTH-1:0] entries_q, entries_d;
    logic [WB_BITS-1:0]       head_q, head_d, tail_q, tail_d;
    logic [WB_BITS-1:0]       tail_m1_s;
    logic [WB_BITS:0]         count_q, count_d;
    logic                     empty_q, empty_d, full_q, full_d;
    logic                     coalesce_s, accept_s, alloc_s, drain_s;
    logic                     unused_s;

    assign tail_m1_s = tail_q - WB_BITS'(1);
    assign unused_s  = ^{sq_store_addr[2:0], ld_lookup_addr[2:0]};

    // Handshake decisions; acceptance never looks at dc_wr_ack
    always_comb begin
        // The head is excluded from merging because its data is under handshake.
        coalesce_s = sq_store_request && entries_q[tail_m1_s].valid &&
                     (entries_q[tail_m1_s].addr == sq_store_addr[63:3]) &&
                     (tail_m1_s != head_q);
        accept_s   = !reset && sq_store_request && (coalesce_s || !full_q);
        alloc_s    = accept_s && !coalesce_s;
        drain_s    = entries_q[head_q].valid && dc_wr_ack;
    end

    // FIFO next-state: drain at head, allocate at tail, merge into tail-1
    always_comb begin
        entries_d = entries_q;
        if (drain_s) begin
            entries_d[head_q].valid = 1'b0;
            head_d = wb_ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (alloc_s) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].addr  = sq_store_addr[63:3];
            entries_d[tail_q].data  = sq_store_data;
            tail_d = wb_ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (accept_s && coalesce_s) begin
            entries_d[tail_m1_s].data = sq_store_data;
        end else begin
            entries_d[tail_m1_s].data = entries_d[tail_m1_s].data;
        end
        count_d = count_q + (WB_BITS+1)'(alloc_s) - (WB_BITS+1)'(drain_s);
        full_d  = (count_d == (WB_BITS+1)'(WB_DEPTH));
        empty_d = (count_d == (WB_BITS+1)'(0));
    end

    // State registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    assign sq_store_success = accept_s;
    assign dc_wr_request    = entries_q[head_q].valid;
    assign dc_wr_addr       = entries_q[head_q].valid ? {entries_q[head_q].addr, 3'b000} : 64'd0;
    assign dc_wr_data       = entries_q[head_q].valid ? entries_q[head_q].data : 64'd0;
    assign wb_count         = count_q;
    assign wb_empty         = empty_q;
    assign wb_full          = full_q;

    wb_fwd_match u_fwd (
        .entries      (entries_q),
        .head         (head_q),
        .lookup_valid (ld_lookup_valid),
        .lookup_qaddr (ld_lookup_addr[63:3]),
        .in_valid     (accept_s),
        .in_qaddr     (sq_store_addr[63:3]),
        .in_data      (sq_store_data),
        .hit          (ld_fwd_hit),
        .data         (ld_fwd_data)
    );

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer. A queue holds the expected
// buffered stores in acceptance order; D-cache writes pop and compare it.
module tb_store_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        sq_store_request;
    logic [63:0] sq_store_addr, sq_store_data;
    logic        sq_store_success;
    logic        dc_wr_request;
    logic [63:0] dc_wr_addr, dc_wr_data;
    logic        dc_wr_ack;
    logic        ld_lookup_valid;
    logic [63:0] ld_lookup_addr;
    logic        ld_fwd_hit;
    logic [63:0] ld_fwd_data;
    logic [2:0]  wb_count;
    logic        wb_empty, wb_full;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    always #5 clock = ~clock;

    store_write_buffer dut (
        .clock            (clock),
        .reset            (reset),
        .sq_store_request (sq_store_request),
        .sq_store_addr    (sq_store_addr),
        .sq_store_data    (sq_store_data),
        .sq_store_success (sq_store_success),
        .dc_wr_request    (dc_wr_request),
        .dc_wr_addr       (dc_wr_addr),
        .dc_wr_data       (dc_wr_data),
        .dc_wr_ack        (dc_wr_ack),
        .ld_lookup_valid  (ld_lookup_valid),
        .ld_lookup_addr   (ld_lookup_addr),
        .ld_fwd_hit       (ld_fwd_hit),
        .ld_fwd_data      (ld_fwd_data),
        .wb_count         (wb_count),
        .wb_empty         (wb_empty),
        .wb_full          (wb_full)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model at negedge,
    // then advance the model across the rising edge.
    task automatic step(input logic req, input logic [63:0] a, input logic [63:0] d,
                        input logic ack, input logic lv, input logic [63:0] la);
        int    cnt;
        logic  coal, acc, fhit;
        logic [63:0] fdata;
        sb_t   e;
        sq_store_request = req;
        sq_store_addr    = a;
        sq_store_data    = d;
        dc_wr_ack        = ack;
        ld_lookup_valid  = lv;
        ld_lookup_addr   = la;
        @(negedge clock);
        cnt = sb_q.size();
        check_eq("wb_count", 64'(wb_count), 64'(cnt));
        check_eq("wb_empty", 64'(wb_empty), 64'(cnt == 0));
        check_eq("wb_full", 64'(wb_full), 64'(cnt == 4));
        check_eq("dc_wr_request", 64'(dc_wr_request), 64'(cnt != 0));
        if (cnt != 0) begin
            check_eq("dc_wr_addr", dc_wr_addr, sb_q[0].addr);
            check_eq("dc_wr_data", dc_wr_data, sb_q[0].data);
        end
        coal = req && (cnt >= 2) && (sb_q[cnt-1].addr[63:3] == a[63:3]);
        acc  = req && (coal || cnt < 4);
        check_eq("sq_store_success", 64'(sq_store_success), 64'(acc));
        fhit  = 1'b0;
        fdata = 64'd0;
        if (lv) begin
            for (int i = 0; i < cnt; i++) begin
                if (sb_q[i].addr[63:3] == la[63:3]) begin
                    fhit  = 1'b1;
                    fdata = sb_q[i].data;
                end
            end
            if (acc && a[63:3] == la[63:3]) begin
                fhit  = 1'b1;
                fdata = d;
            end
        end
        check_eq("ld_fwd_hit", 64'(ld_fwd_hit), 64'(fhit));
        check_eq("ld_fwd_data", ld_fwd_data, fdata);
        if (cnt != 0 && ack) begin
            void'(sb_q.pop_front());
        end
        if (acc) begin
            if (coal) begin
                e      = sb_q[sb_q.size()-1];
                e.data = d;
                sb_q[sb_q.size()-1] = e;
            end else begin
                e.addr = {a[63:3], 3'b000};
                e.data = d;
                sb_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, 64'd0, 64'd0, ack, 1'b0, 64'd0);
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d, input logic ack);
        step(1'b1, a, d, ack, 1'b0, 64'd0);
    endtask

    initial begin
        reset            = 1'b1;
        sq_store_request = 1'b0;
        sq_store_addr    = 64'd0;
        sq_store_data    = 64'd0;
        dc_wr_ack        = 1'b0;
        ld_lookup_valid  = 1'b0;
        ld_lookup_addr   = 64'd0;

        // Reset state
        @(negedge clock);
        check_eq("rst_wr_request", 64'(dc_wr_request), 64'd0);
        check_eq("rst_wr_addr", dc_wr_addr, 64'd0);
        check_eq("rst_wr_data", dc_wr_data, 64'd0);
        check_eq("rst_count", 64'(wb_count), 64'd0);
        check_eq("rst_empty", 64'(wb_empty), 64'd1);
        check_eq("rst_full", 64'(wb_full), 64'd0);
        check_eq("rst_success", 64'(sq_store_success), 64'd0);
        check_eq("rst_fwd_hit", 64'(ld_fwd_hit), 64'd0);
        check_eq("rst_fwd_data", ld_fwd_data, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single store, one-cycle residency, drain
        store(64'h10, 64'h3, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill, reject when full, accept after one drain, ordered drain
        store(64'h0, 64'hA0, 1'b0);
        store(64'h8, 64'hA1, 1'b0);
        store(64'h10, 64'hA2, 1'b0);
        store(64'h18, 64'hA3, 1'b0);
        store(64'h40, 64'hA4, 1'b0);
        store(64'h40, 64'hA4, 1'b1);
        store(64'h40, 64'hA4, 1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Coalesce into youngest non-head entry
        store(64'h8, 64'h1, 1'b0);
        store(64'h20, 64'h5, 1'b0);
        store(64'h20, 64'h9, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Head-only: second store to head address allocates; then forwarding
        store(64'h20, 64'h5, 1'b0);
        store(64'h20, 64'h9, 1'b0);
        step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h24);
        step(1'b0, 64'd0, 64'd0, 1'b0, 1'b1, 64'h28);
        step(1'b1, 64'h28, 64'h7, 1'b0, 1'b1, 64'h28);
        step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 64'h28);
        // Head still forwards during its ack cycle
        step(1'b0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h20);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Simultaneous accept and drain at count 2, wrapping the pointers
        store(64'h100, 64'h11, 1'b0);
        store(64'h108, 64'h12, 1'b0);
        for (int i = 0; i < 10; i++) begin
            store(64'h200 + 64'(8 * i), {$urandom, $urandom}, 1'b1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset while full with a request held
        store(64'h300, 64'h21, 1'b0);
        store(64'h308, 64'h22, 1'b0);
        store(64'h310, 64'h23, 1'b0);
        store(64'h318, 64'h24, 1'b0);
        sq_store_request = 1'b1;
        sq_store_addr    = 64'h380;
        sq_store_data    = 64'h25;
        dc_wr_ack        = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check_eq("rr_wr_request", 64'(dc_wr_request), 64'd0);
        check_eq("rr_count", 64'(wb_count), 64'd0);
        check_eq("rr_empty", 64'(wb_empty), 64'd1);
        check_eq("rr_success", 64'(sq_store_success), 64'd0);
        @(negedge clock);
        check_eq("rr_wr_request_2", 64'(dc_wr_request), 64'd0);
        check_eq("rr_count_2", 64'(wb_count), 64'd0);
        @(posedge clock);
        #1;
        sq_store_request = 1'b0;
        reset = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Post-commit write buffer directly downstream of the store queue (sq).
- Accepts committed stores (address, 64-bit data) one per cycle from sq over its store_request/store_success handshake and holds them in a small FIFO.
- Drains them in order to the D-cache write port.
- Supplies store-to-load forwarding for buffered stores, so the sq can free entries at commit without losing visibility of not-yet-written data.

Parameters:
- WB_DEPTH, 4, number of buffer entries (power of two, >=2).
- WB_BITS, 2, log2(WB_DEPTH); pointer width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sq_store_request  in  1  sq presents a committed store this cycle.
- sq_store_addr  in  64  byte address of the store; bits [2:0] ignored (quadword store).
- sq_store_data  in  64  store value.
- sq_store_success  out  1  combinational; store accepted this cycle (sq frees its head on this).
- dc_wr_request  out  1  head entry valid, write requested.
- dc_wr_addr  out  64  head entry address, bits [2:0] forced to 0.
- dc_wr_data  out  64  head entry data.
- dc_wr_ack  in  1  D-cache accepted the write this cycle.
- ld_lookup_valid  in  1  load address probe valid.
- ld_lookup_addr  in  64  load byte address; compared on bits [63:3].
- ld_fwd_hit  out  1  combinational; probe matched a buffered or incoming store.
- ld_fwd_data  out  64  data of youngest matching store; 0 when no hit.
- wb_count  out  WB_BITS+1  number of valid entries.
- wb_empty  out  1  wb_count == 0.
- wb_full  out  1  wb_count == WB_DEPTH.

Behaviour:
- Reset (async): head=tail=0, all valid bits 0, entry data/addr 0. Outputs: dc_wr_request 0, dc_wr_addr 0, dc_wr_data 0, wb_count 0, wb_empty 1, wb_full 0, sq_store_success 0, ld_fwd_hit 0, ld_fwd_data 0. Reset mid-drain drops all buffered stores; no write completes after reset asserts.
- Storage: circular FIFO; entry = {valid, addr[63:3], data[63:0]}; head/tail wrap modulo WB_DEPTH.
- Drain: dc_wr_request = valid[head]; addr/data driven from head entry and held stable until ack. On dc_wr_ack && dc_wr_request at posedge: clear valid[head], head++. dc_wr_ack without request is ignored.
- Coalesce: if sq_store_request, the youngest valid entry (tail-1) matches addr[63:3], and that entry is NOT head, then overwrite its data and do not allocate. Merging into the head is never allowed (head data is under handshake).
- Accept: sq_store_success = sq_store_request && (coalesce || !wb_full). No dependence on dc_wr_ack: no combinational path from D-cache to sq. When full and not coalescing, success=0 and sq retries.
- Allocate (accept && !coalesce): write entry at tail, tail++.
- Latency: a store accepted into an empty buffer at edge N drives dc_wr_request=1 in cycle N+1; minimum 1 cycle buffer residency.
- Simultaneous accept+drain: both occur; wb_count unchanged. Full with ack: drain occurs, success still 0 that cycle, accept possible next cycle.
- Count: wb_count += alloc - drain; wb_full/wb_empty are registered-consistent with wb_count.
- Forwarding (combinational): match all valid entries plus the incoming store if sq_store_success. Priority: incoming > tail-1 > ... > head. The head entry still forwards in its ack cycle. ld_lookup_valid=0 forces hit=0, data=0.
- Mispredict/squash: not an input; buffered stores are architecturally committed and never flushed.
- Ordering: D-cache writes issue in acceptance order; a coalesced value is written once with the latest data.

Decomposition:
- Shared package: WB_DEPTH/WB_BITS defines alongside SQ_BITS; typedef WB_ENTRY {valid, addr, data}.
- One natural sub-module: wb_fwd_match. Priority age-ordered address comparator over entries rotated from head, returning hit and data.
- FIFO control stays in the top.

Test Plan:
- Reset, then one store addr 0x10 data 0x3 -> success=1 same cycle; next cycle dc_wr_request=1, dc_wr_addr=0x10, dc_wr_data=0x3, wb_count=1; ack -> wb_empty=1 next cycle.
- Hold dc_wr_ack=0, push 4 stores to 0x0,0x8,0x10,0x18 -> wb_full=1. Fifth store to 0x40 -> success=0. Ack once -> the 0x40 store is accepted the following cycle, and writes appear in order 0x0,0x8,0x10,0x18,0x40.
- Coalesce: ack=0, stores 0x8/0x1, then 0x20/0x5, then 0x20/0x9 -> wb_count=2. Drain yields 0x8/0x1 then 0x20/0x9. Head-only case: second store to the head address allocates a new entry.
- Forwarding: buffered 0x20/0x5 and 0x20/0x9 (head busy). Probe 0x24 -> hit=1, data=0x9. Probe 0x28 -> hit=0. Same-cycle incoming store 0x28/0x7 with probe 0x28 -> hit=1, data=0x7.
- Simultaneous accept+ack at count=2 -> count stays 2; head advances and tail advances; wrap past index 3 is verified over 10 stores.
- Assert reset while full with request held -> next sample: dc_wr_request=0, wb_count=0, wb_empty=1, and no further writes issued.
